line_buf_mem: RTL and testbench

Line-buffer memory unit that sits directly upstream of the control unit. It accepts a raster pixel stream and writes one image row into each of NM rotating line banks. It reports per-bank full and minimum-fill status, and serves one registered read per bank per cycle at the column address the control unit drives. A bank is released for refill when the control unit pulses `mem_used` for it.

---
 rtl/conveng_pkg.sv | 21 ++
 rtl/line_bank.sv | 54 +++++
 rtl/line_buf_mem.sv | 149 ++++++++++++++
 tb/tb_line_buf_mem.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conveng_pkg.sv
// ---------------------------------------------------------------------------
// conveng_pkg
// Shared definitions for the line-buffer / convolution engine blocks.
//   DEF_XB  default column (address) width, each line bank is 2**DEF_XB deep
//   DEF_YB  default row counter width
//   DEF_PB  default pixel width
//   DEF_NM  default number of rotating line banks (power of two, >= 2)
//   pix_t   one pixel at the default pixel width
//   col_t   one column index at the default column width
// ---------------------------------------------------------------------------
package conveng_pkg;

    localparam int DEF_XB = 10;
    localparam int DEF_YB = 10;
    localparam int DEF_PB = 8;
    localparam int DEF_NM = 4;

    typedef logic [DEF_PB-1:0] pix_t;
    typedef logic [DEF_XB-1:0] col_t;

endpackage

// File: rtl/line_bank.sv
// ---------------------------------------------------------------------------
// line_bank
// One image-row RAM: synchronous write, registered read, read-first on a
// same-address collision. Only the read register is reset; the array is not.
//   clk      clock
//   rst      asynchronous active-low reset (clears rd_data only)
//   wr_en    write strobe
//   wr_addr  write column
//   wr_data  write pixel
//   rd_addr  read column, sampled every cycle
//   rd_data  pixel at rd_addr, one cycle later
// ---------------------------------------------------------------------------
module line_bank
    import conveng_pkg::*;
#(
    parameter int XB = DEF_XB,
    parameter int PB = DEF_PB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [XB-1:0] wr_addr,
    input  logic [PB-1:0] wr_data,
    input  logic [XB-1:0] rd_addr,
    output logic [PB-1:0] rd_data
);

    logic [PB-1:0] mem [2**XB];
    logic [PB-1:0] rd_data_d;
    logic [PB-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The array is read before this edge's write lands, which gives
    // read-first behaviour when both ports hit the same column.
    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buf_mem.sv
// ---------------------------------------------------------------------------
// line_buf_mem
// Writes a raster pixel stream one row per bank into NM rotating line banks,
// tracks which banks hold a complete unreleased row, and serves one
// registered read per bank per cycle for the downstream control unit.
//   clk         clock
//   rst         asynchronous active-low reset
//   cfg_width   last column index (row = cfg_width+1 pixels), held per frame
//   cfg_height  last row index (frame = cfg_height+1 rows), held per frame
//   in_valid    input pixel valid
//   in_pixel    input pixel
//   in_ready    a pixel is accepted this cycle when in_valid is also high
//   mem_used    per-bank one-cycle release pulse from the control unit
//   mb_rd_addr  per-bank read column
//   mb_full     per-bank "complete unreleased row" flag
//   mb_minfill  bit k set when at least k+1 banks are full
//   pu_data     per-bank registered read data
//   frame_done  one-cycle pulse after the last pixel of a frame is written
// ---------------------------------------------------------------------------
module line_buf_mem
    import conveng_pkg::*;
#(
    parameter int XB = DEF_XB,
    parameter int YB = DEF_YB,
    parameter int PB = DEF_PB,
    parameter int NM = DEF_NM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XB-1:0]          cfg_width,
    input  logic [YB-1:0]          cfg_height,
    input  logic                   in_valid,
    input  logic [PB-1:0]          in_pixel,
    output logic                   in_ready,
    input  logic [NM-1:0]          mem_used,
    input  logic [NM-1:0][XB-1:0]  mb_rd_addr,
    output logic [NM-1:0]          mb_full,
    output logic [NM-1:0]          mb_minfill,
    output logic [NM-1:0][PB-1:0]  pu_data,
    output logic                   frame_done
);

    localparam int BB = $clog2(NM);

    logic [BB-1:0] wr_bank_q, wr_bank_d;
    logic [XB-1:0] wr_col_q,  wr_col_d;
    logic [YB-1:0] wr_row_q,  wr_row_d;
    logic [NM-1:0] mb_full_q, mb_full_d;
    logic          frame_done_q, frame_done_d;

    logic          xfer;
    logic          row_end;
    logic [NM-1:0] set_mask;
    logic [NM-1:0] bank_we;
    int            fill_cnt;

    // Ready depends only on the flag of the bank being written, so there is
    // no path from in_valid back to in_ready.
    assign in_ready = ~mb_full_q[wr_bank_q];
    assign xfer     = in_valid & in_ready;
    assign row_end  = xfer && (wr_col_q == cfg_width);

    // Write pointer advance. A finished row marks its bank full and moves on
    // to the next bank; NM is a power of two so the bank index wraps freely.
    // A set and a release of the same bank on one edge resolves to "set".
    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_col_d     = wr_col_q;
        wr_row_d     = wr_row_q;
        frame_done_d = 1'b0;
        set_mask     = '0;
        if (xfer) begin
            if (row_end) begin
                wr_col_d            = '0;
                wr_bank_d           = wr_bank_q + 1'b1;
                set_mask[wr_bank_q] = 1'b1;
                if (wr_row_q == cfg_height) begin
                    wr_row_d     = '0;
                    frame_done_d = 1'b1;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
        mb_full_d = (mb_full_q & ~mem_used) | set_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q    <= '0;
            wr_col_q     <= '0;
            wr_row_q     <= '0;
            mb_full_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_col_q     <= wr_col_d;
            wr_row_q     <= wr_row_d;
            mb_full_q    <= mb_full_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Thermometer fill status from the population count of full banks.
    always_comb begin
        fill_cnt   = 0;
        mb_minfill = '0;
        for (int i = 0; i < NM; i++) begin
            fill_cnt = fill_cnt + (mb_full_q[i] ? 1 : 0);
        end
        for (int k = 0; k < NM; k++) begin
            mb_minfill[k] = (fill_cnt >= k + 1);
        end
    end

    always_comb begin
        bank_we = '0;
        for (int i = 0; i < NM; i++) begin
            bank_we[i] = xfer && (wr_bank_q == BB'(i));
        end
    end

    for (genvar g = 0; g < NM; g++) begin : g_bank
        line_bank #(
            .XB (XB),
            .PB (PB)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bank_we[g]),
            .wr_addr (wr_col_q),
            .wr_data (in_pixel),
            .rd_addr (mb_rd_addr[g]),
            .rd_data (pu_data[g])
        );
    end

    assign mb_full    = mb_full_q;
    assign frame_done = frame_done_q;

    // A controller releasing the bank that is being completed on the same
    // edge has lost track of the fill order.
    a_no_release_on_set : assert property (
        @(posedge clk) disable iff (!rst) ((set_mask & mem_used) == '0)
    );

endmodule

// File: tb/tb_line_buf_mem.sv
// ---------------------------------------------------------------------------
// tb_line_buf_mem
// Directed stimulus for line_buf_mem with a cycle-tagged scoreboard: the
// stimulus pushes the response it expects on a given cycle and a separate
// monitor pops and compares on the falling edge of that cycle.
// ---------------------------------------------------------------------------
module tb_line_buf_mem;
    import conveng_pkg::*;

    localparam int XB = DEF_XB;
    localparam int YB = DEF_YB;
    localparam int PB = DEF_PB;
    localparam int NM = DEF_NM;

    localparam int SIG_FULL = 0;
    localparam int SIG_MINF = 1;
    localparam int SIG_RDY  = 2;
    localparam int SIG_PU   = 3;
    localparam int SIG_FD   = 4;

    typedef struct {
        int    cyc;
        int    sig;
        int    idx;
        int    val;
        string name;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [XB-1:0]         cfg_width;
    logic [YB-1:0]         cfg_height;
    logic                  in_valid;
    pix_t                  in_pixel;
    logic                  in_ready;
    logic [NM-1:0]         mem_used;
    logic [NM-1:0][XB-1:0] mb_rd_addr;
    logic [NM-1:0]         mb_full;
    logic [NM-1:0]         mb_minfill;
    logic [NM-1:0][PB-1:0] pu_data;
    logic                  frame_done;

    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t sb_q[$];

    // Row contents for the first four banks: bank 1 holds 10..13 and
    // bank 0 column 1 holds 0x55 for the read-first collision later.
    int row_pix [4][4] = '{'{8'h00, 8'h55, 8'h02, 8'h03},
                           '{10, 11, 12, 13},
                           '{20, 21, 22, 23},
                           '{30, 31, 32, 33}};

    line_buf_mem #(
        .XB (XB),
        .YB (YB),
        .PB (PB),
        .NM (NM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .mem_used   (mem_used),
        .mb_rd_addr (mb_rd_addr),
        .mb_full    (mb_full),
        .mb_minfill (mb_minfill),
        .pu_data    (pu_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sig, input int idx);
        case (sig)
            SIG_FULL: return 32'(mb_full);
            SIG_MINF: return 32'(mb_minfill);
            SIG_RDY:  return 32'(in_ready);
            SIG_PU:   return 32'(pu_data[idx]);
            default:  return 32'(frame_done);
        endcase
    endfunction

    task automatic expectAt(input int c, input int sig, input int idx, input int val, input string name);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.idx  = idx;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int pix, input logic [NM-1:0] used);
        in_valid = v;
        in_pixel = pix_t'(pix);
        mem_used = used;
        tick();
    endtask

    // Monitor: compare every entry tagged with the cycle now on display.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL %s: cycle %0d never sampled, now %0d", e.name, e.cyc, cyc);
            end else begin
                checkOutput(e.name, sample(e.sig, e.idx), 32'(e.val));
            end
        end
    end

    initial begin
        int rows;
        int s;
        int d;
        int drain;

        rst        = 1'b0;
        in_valid   = 1'b0;
        in_pixel   = '0;
        mem_used   = '0;
        mb_rd_addr = '0;
        cfg_width  = XB'(3);
        cfg_height = YB'(7);

        // Reset state, sampled while reset is held across clock edges.
        tick();
        expectAt(cyc + 1, SIG_FULL, 0, 0, "rst_full");
        expectAt(cyc + 1, SIG_MINF, 0, 0, "rst_minfill");
        expectAt(cyc + 1, SIG_RDY,  0, 1, "rst_ready");
        expectAt(cyc + 1, SIG_FD,   0, 0, "rst_frame_done");
        for (int i = 0; i < NM; i++) expectAt(cyc + 1, SIG_PU, i, 0, "rst_pu_data");
        tick();
        tick();
        rst = 1'b1;

        // Four rows of four pixels back to back, no releases.
        for (int k = 0; k < 16; k++) begin
            rows = (k + 1) / 4;
            expectAt(cyc + 1, SIG_FULL, 0, (1 << rows) - 1, "stream_full");
            expectAt(cyc + 1, SIG_MINF, 0, (1 << rows) - 1, "stream_minfill");
            expectAt(cyc + 1, SIG_RDY,  0, (rows == 4) ? 0 : 1, "stream_ready");
            expectAt(cyc + 1, SIG_FD,   0, 0, "stream_frame_done");
            applyStimulus(1'b1, row_pix[k / 4][k % 4], '0);
        end
        in_valid = 1'b0;

        // Read path: one cycle latency from address to data.
        mb_rd_addr[1] = col_t'(2);
        mb_rd_addr[2] = col_t'(3);
        mb_rd_addr[3] = col_t'(1);
        expectAt(cyc,     SIG_PU, 1, 10, "rd_latency_old");
        expectAt(cyc + 1, SIG_PU, 1, 12, "rd_bank1_addr2");
        expectAt(cyc + 1, SIG_PU, 2, 23, "rd_bank2_addr3");
        expectAt(cyc + 1, SIG_PU, 3, 31, "rd_bank3_addr1");
        tick();
        mb_rd_addr[1] = col_t'(3);
        expectAt(cyc + 1, SIG_PU, 1, 13, "rd_bank1_addr3");
        tick();

        // Full stall with in_valid held high.
        for (int i = 0; i < 2; i++) begin
            expectAt(cyc + 1, SIG_FULL, 0, 4'b1111, "stall_full");
            expectAt(cyc + 1, SIG_RDY,  0, 0, "stall_ready");
            applyStimulus(1'b1, 8'hEE, '0);
        end
        expectAt(cyc + 1, SIG_FULL, 0, 4'b1110, "release_full");
        expectAt(cyc + 1, SIG_MINF, 0, 4'b0111, "release_minfill");
        expectAt(cyc + 1, SIG_RDY,  0, 1, "release_ready");
        applyStimulus(1'b1, 8'hEE, 4'b0001);

        // Refill bank 0; column 1 collides with a read of the same column.
        mb_rd_addr[0] = col_t'(0);
        expectAt(cyc + 1, SIG_PU,   0, 8'h00, "refill_rd_first_col0");
        expectAt(cyc + 1, SIG_FULL, 0, 4'b1110, "refill_full0");
        applyStimulus(1'b1, 8'h40, '0);
        mb_rd_addr[0] = col_t'(1);
        expectAt(cyc + 1, SIG_PU,   0, 8'h55, "rd_first_collision");
        expectAt(cyc + 1, SIG_RDY,  0, 1, "refill_ready");
        applyStimulus(1'b1, 8'hAA, '0);
        expectAt(cyc + 1, SIG_PU,   0, 8'hAA, "rd_after_write");
        applyStimulus(1'b1, 8'h42, '0);
        expectAt(cyc + 1, SIG_FULL, 0, 4'b1111, "refill_full_set");
        expectAt(cyc + 1, SIG_MINF, 0, 4'b1111, "refill_minfill");
        expectAt(cyc + 1, SIG_RDY,  0, 0, "refill_ready_drop");
        applyStimulus(1'b1, 8'h43, '0);

        // Releasing a bank other than the write target leaves the stall.
        expectAt(cyc + 1, SIG_FULL, 0, 4'b1011, "other_release_full");
        expectAt(cyc + 1, SIG_MINF, 0, 4'b0111, "other_release_minfill");
        expectAt(cyc + 1, SIG_RDY,  0, 0, "other_release_ready");
        applyStimulus(1'b1, 8'hEE, 4'b0100);
        applyStimulus(1'b0, 0, '0);

        // Two frames of 2x2 with each bank released as soon as it fills.
        rst = 1'b0;
        tick();
        cfg_width  = XB'(1);
        cfg_height = YB'(1);
        rst = 1'b1;
        s = cyc;
        for (int i = 0; i < 8; i++) begin
            d = i + 1;
            expectAt(cyc + 1, SIG_FULL, 0, (d % 2 == 0) ? (1 << (d / 2 - 1)) : 0, "frame_full");
            expectAt(cyc + 1, SIG_MINF, 0, (d % 2 == 0) ? 1 : 0, "frame_minfill");
            expectAt(cyc + 1, SIG_RDY,  0, 1, "frame_ready");
            expectAt(cyc + 1, SIG_FD,   0, (d == 4 || d == 8) ? 1 : 0, "frame_done_pulse");
            applyStimulus(1'b1, 8'h80 + i, (i >= 2 && i % 2 == 0) ? NM'(1 << (i / 2 - 1)) : '0);
        end
        expectAt(cyc + 1, SIG_FULL, 0, 0, "frame_last_release");
        expectAt(cyc + 1, SIG_FD,   0, 0, "frame_done_clear");
        applyStimulus(1'b0, 0, 4'b1000);
        if (cyc != s + 9) $display("[TB] note: frame section cycle offset %0d", cyc - s);

        // Async reset in the middle of a row.
        cfg_width = XB'(3);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) expectAt(cyc + 1, SIG_FULL, 0, 4'b0001, "pre_reset_full");
            applyStimulus(1'b1, (i < 4) ? 8'h11 + i : 8'h21 + i - 4, '0);
        end
        applyStimulus(1'b0, 0, '0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_full",       32'(mb_full),    32'd0);
        checkOutput("async_rst_minfill",    32'(mb_minfill), 32'd0);
        checkOutput("async_rst_ready",      32'(in_ready),   32'd1);
        checkOutput("async_rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("async_rst_pu_data",    32'(pu_data),    32'd0);
        tick();
        rst = 1'b1;
        mb_rd_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                expectAt(cyc + 1, SIG_FULL, 0, 4'b0001, "post_reset_bank0_full");
                expectAt(cyc + 1, SIG_RDY,  0, 1, "post_reset_ready");
            end
            applyStimulus(1'b1, 8'h77 + i, '0);
        end
        expectAt(cyc + 1, SIG_PU, 0, 8'h77, "post_reset_bank0_col0");
        applyStimulus(1'b0, 0, '0);

        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            tick();
            drain++;
        end
        if (sb_q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
